// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C slave responder.
// FSM state encoding, ACK/NACK levels and the transfer direction enum.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_WAIT_STOP
    } i2c_slv_state_t;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } i2c_op_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: oversampling front-end for SCL/SDA.
// Synchronizes both lines and emits registered bus events.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_bit,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_q;
    logic [SYNC_STAGES-1:0] sda_q;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_d;
    logic                   sda_d;

    assign scl_s   = scl_q[SYNC_STAGES-1];
    assign sda_s   = sda_q[SYNC_STAGES-1];
    assign sda_bit = sda_d;

    // synchronizer chains plus history flops; idle bus reads high
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q <= '1;
            sda_q <= '1;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_q <= {scl_q[SYNC_STAGES-2:0], scl};
            sda_q <= {sda_q[SYNC_STAGES-2:0], sda};
            scl_d <= scl_s;
            sda_d <= sda_s;
        end
    end

    // START/STOP need SCL steady high, so SDA moving with SCL is data
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
        end else begin
            scl_rise <= scl_s & ~scl_d;
            scl_fall <= ~scl_s & scl_d;
            start    <= scl_s & scl_d & ~sda_s & sda_d;
            stop     <= scl_s & scl_d & sda_s & ~sda_d;
        end
    end

endmodule

// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: single-address I2C target with a byte interface.
// Receives writes, serves reads, ACKs on an open-drain SDA drive.
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter int                        I2C_ADDR_WIDTH = 7,
    parameter int                        I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22,
    parameter int                        SYNC_STAGES    = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_o,
    output logic                      busy_o,
    output logic                      xfer_start_o,
    output logic                      xfer_op_o,
    output logic                      wr_valid_o,
    output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
    output logic                      rd_req_o,
    input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
    output logic                      stop_o
);

    i2c_slv_state_t            state;
    i2c_slv_state_t            state_n;
    logic [2:0]                cnt;
    logic [2:0]                cnt_n;
    logic                      full;
    logic                      full_n;
    logic [I2C_DATA_WIDTH-1:0] shreg;
    logic [I2C_DATA_WIDTH-1:0] shreg_n;
    logic [I2C_DATA_WIDTH-1:0] wr_data_n;
    logic                      ack_bit;
    logic                      ack_n;
    logic                      sda_n;
    logic                      busy_n;
    i2c_op_t                   op;
    i2c_op_t                   op_n;
    logic                      xfer_start_n;
    logic                      wr_valid_n;
    logic                      rd_req_n;
    logic                      stop_n;
    logic                      sda_bit;
    logic                      scl_rise;
    logic                      scl_fall;
    logic                      bus_start;
    logic                      bus_stop;
    logic                      addr_hit;
    logic                      counting;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk_i),
        .rst     (rst_i),
        .scl     (scl_i),
        .sda     (sda_i),
        .sda_bit (sda_bit),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (bus_start),
        .stop    (bus_stop)
    );

    assign addr_hit  = shreg[I2C_DATA_WIDTH-1:1] == SLAVE_ADDR;
    assign counting  = state inside {ST_ADDR, ST_WR_BYTE, ST_RD_BYTE};
    assign xfer_op_o = op;

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_n;
    end

    // next state: bit events advance, START/STOP override (STOP wins)
    always_comb begin
        state_n = state;
        if (scl_fall) begin
            unique case (state)
                ST_ADDR:
                    if (full) state_n = addr_hit ? ST_ADDR_ACK : ST_WAIT_STOP;
                ST_ADDR_ACK:
                    state_n = (op == READ) ? ST_RD_BYTE : ST_WR_BYTE;
                ST_WR_BYTE:
                    if (full) state_n = ST_WR_ACK;
                ST_WR_ACK:
                    state_n = ST_WR_BYTE;
                ST_RD_BYTE:
                    if (full) state_n = ST_RD_ACK;
                ST_RD_ACK:
                    state_n = (ack_bit == I2C_ACK) ? ST_RD_BYTE : ST_WAIT_STOP;
                default:
                    state_n = state;
            endcase
        end
        if (bus_start) state_n = ST_ADDR;
        if (bus_stop)  state_n = ST_IDLE;
    end

    // outputs and datapath next values; full marks 8 bits seen
    always_comb begin
        cnt_n        = cnt;
        full_n       = full;
        shreg_n      = shreg;
        ack_n        = ack_bit;
        sda_n        = sda_o;
        busy_n       = busy_o;
        op_n         = op;
        wr_data_n    = wr_data_o;
        xfer_start_n = 1'b0;
        wr_valid_n   = 1'b0;
        rd_req_n     = 1'b0;
        stop_n       = 1'b0;
        if (rd_req_o && state == ST_RD_BYTE) begin
            shreg_n = rd_data_i;
            sda_n   = rd_data_i[I2C_DATA_WIDTH-1];
        end
        if (scl_rise) begin
            if (counting) begin
                cnt_n = cnt + 3'd1;
                if (cnt == 3'd7) full_n = 1'b1;
                if (state != ST_RD_BYTE)
                    shreg_n = {shreg[I2C_DATA_WIDTH-2:0], sda_bit};
            end
            if (state == ST_RD_ACK) ack_n = sda_bit;
        end
        if (scl_fall) begin
            unique case (state)
                ST_ADDR:
                    if (full) begin
                        cnt_n  = 3'd0;
                        full_n = 1'b0;
                        if (addr_hit) begin
                            sda_n        = I2C_ACK;
                            xfer_start_n = 1'b1;
                            busy_n       = 1'b1;
                            op_n         = i2c_op_t'(shreg[0]);
                        end else begin
                            busy_n = 1'b0;
                        end
                    end
                ST_ADDR_ACK: begin
                    sda_n    = 1'b1;
                    rd_req_n = (op == READ);
                end
                ST_WR_BYTE:
                    if (full) begin
                        cnt_n      = 3'd0;
                        full_n     = 1'b0;
                        sda_n      = I2C_ACK;
                        wr_valid_n = 1'b1;
                        wr_data_n  = shreg;
                    end
                ST_WR_ACK: begin
                    sda_n = 1'b1;
                    cnt_n = 3'd0;
                end
                ST_RD_BYTE:
                    if (full) begin
                        cnt_n  = 3'd0;
                        full_n = 1'b0;
                        sda_n  = 1'b1;
                    end else begin
                        sda_n   = shreg[I2C_DATA_WIDTH-2];
                        shreg_n = {shreg[I2C_DATA_WIDTH-2:0], 1'b0};
                    end
                ST_RD_ACK: begin
                    cnt_n    = 3'd0;
                    rd_req_n = (ack_bit == I2C_ACK);
                end
                default: ;
            endcase
        end
        if (bus_start) begin
            sda_n  = 1'b1;
            cnt_n  = 3'd0;
            full_n = 1'b0;
        end
        if (bus_stop) begin
            sda_n  = 1'b1;
            cnt_n  = 3'd0;
            full_n = 1'b0;
            busy_n = 1'b0;
            stop_n = busy_o;
        end
    end

    // datapath and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt          <= 3'd0;
            full         <= 1'b0;
            shreg        <= '0;
            ack_bit      <= I2C_NACK;
            sda_o        <= 1'b1;
            busy_o       <= 1'b0;
            op           <= WRITE;
            wr_data_o    <= '0;
            xfer_start_o <= 1'b0;
            wr_valid_o   <= 1'b0;
            rd_req_o     <= 1'b0;
            stop_o       <= 1'b0;
        end else begin
            cnt          <= cnt_n;
            full         <= full_n;
            shreg        <= shreg_n;
            ack_bit      <= ack_n;
            sda_o        <= sda_n;
            busy_o       <= busy_n;
            op           <= op_n;
            wr_data_o    <= wr_data_n;
            xfer_start_o <= xfer_start_n;
            wr_valid_o   <= wr_valid_n;
            rd_req_o     <= rd_req_n;
            stop_o       <= stop_n;
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder: bus-level master model driving the responder.
// Vector table of transfers plus hand-written corner sequences.
module tb_i2c_slave_responder;
    import i2c_pkg::*;

    localparam int Q = 10;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_o;
    logic       busy;
    logic       xs;
    logic       xop;
    logic       wv;
    logic       rr;
    logic       sp;
    logic [7:0] wdat;
    logic [7:0] rdat;
    wire        sda_bus = sda_m & sda_o;

    always #5 clk = ~clk;

    i2c_slave_responder dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .scl_i       (scl_m),
        .sda_i       (sda_bus),
        .sda_o       (sda_o),
        .busy_o      (busy),
        .xfer_start_o(xs),
        .xfer_op_o   (xop),
        .wr_valid_o  (wv),
        .wr_data_o   (wdat),
        .rd_req_o    (rr),
        .rd_data_i   (rdat),
        .stop_o      (sp)
    );

    logic [7:0] rd_mem [16];
    int         rd_idx = 0;
    assign rdat = rd_mem[rd_idx[3:0]];

    always @(posedge clk) if (rr) rd_idx <= rd_idx + 1;

    logic [7:0] wr_obs [64];
    logic       op_obs [16];
    int         wv_cnt  = 0;
    int         xs_cnt  = 0;
    int         sp_cnt  = 0;
    int         low_cnt = 0;

    always @(negedge clk) begin
        if (wv) begin
            wr_obs[wv_cnt[5:0]] <= wdat;
            wv_cnt <= wv_cnt + 1;
        end
        if (xs) begin
            op_obs[xs_cnt[3:0]] <= xop;
            xs_cnt <= xs_cnt + 1;
        end
        if (sp) sp_cnt <= sp_cnt + 1;
        if (!sda_o) low_cnt <= low_cnt + 1;
    end

    int errors = 0;
    int checks = 0;
    logic       exp_op [$];
    logic [7:0] exp_wr [$];

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        int         n;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       hit;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_cyc(input logic b, output logic r);
        sda_m = b;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        r = sda_bus;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic m_start();
        if (!scl_m) begin
            sda_m = 1'b1;
            tick(Q);
            scl_m = 1'b1;
            tick(Q);
        end
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic m_stop();
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b1;
        tick(Q);
    endtask

    task automatic m_write(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_cyc(d[i], r);
        bit_cyc(1'b1, ack);
    endtask

    task automatic m_read(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_cyc(1'b1, r);
            d[i] = r;
        end
        bit_cyc(nack, r);
    endtask

    task automatic drain(input int xs0, input int wv0);
        logic [3:0] oi;
        logic [5:0] wi;
        logic       eo;
        logic [7:0] ew;
        int         k;
        k = 0;
        while (exp_op.size() > 0) begin
            eo = exp_op.pop_front();
            oi = 4'(xs0 + k);
            if (k < xs_cnt - xs0) check("xfer_op", 32'(op_obs[oi]), 32'(eo));
            k++;
        end
        k = 0;
        while (exp_wr.size() > 0) begin
            ew = exp_wr.pop_front();
            wi = 6'(wv0 + k);
            if (k < wv_cnt - wv0) check("wr_data", 32'(wr_obs[wi]), 32'(ew));
            k++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int         xs0, wv0, sp0, rr0, low0, nxs, nwr;
        logic       a;
        logic [7:0] got;
        logic [7:0] dk;
        xs0  = xs_cnt;
        wv0  = wv_cnt;
        sp0  = sp_cnt;
        rr0  = rd_idx;
        low0 = low_cnt;
        if (v.hit) begin
            exp_op.push_back(v.rw);
            if (!v.rw) begin
                exp_wr.push_back(v.d0);
                if (v.n > 1) exp_wr.push_back(v.d1);
            end
        end
        nxs = exp_op.size();
        nwr = exp_wr.size();
        rd_mem[4'(rr0)]     = v.d0;
        rd_mem[4'(rr0 + 1)] = v.d1;
        m_start();
        m_write({v.addr, v.rw}, a);
        check("addr_ack", 32'(a), 32'(!v.hit));
        if (v.hit) begin
            check("busy_xfer", 32'(busy), 32'd1);
            for (int k = 0; k < v.n; k++) begin
                dk = (k == 0) ? v.d0 : v.d1;
                if (!v.rw) begin
                    m_write(dk, a);
                    check("wr_ack", 32'(a), 32'd0);
                end else begin
                    m_read(k == v.n - 1, got);
                    check("rd_data", 32'(got), 32'(dk));
                end
            end
            if (v.rw) check("sda_rel_nack", 32'(sda_o), 32'd1);
        end
        m_stop();
        tick(Q);
        check("busy_end", 32'(busy), 32'd0);
        check("stop_cnt", 32'(sp_cnt - sp0), 32'(v.hit));
        check("xs_cnt", 32'(xs_cnt - xs0), 32'(nxs));
        check("wv_cnt", 32'(wv_cnt - wv0), 32'(nwr));
        check("rd_req_cnt", 32'(rd_idx - rr0),
              32'((v.hit && v.rw) ? v.n : 0));
        if (!v.hit) check("sda_quiet", 32'(low_cnt - low0), 32'd0);
        drain(xs0, wv0);
    endtask

    initial begin
        int         xs0, wv0, sp0, rr0;
        logic       a;
        logic       r;
        logic [7:0] got;
        vec_t       v;

        vecs[0] = '{7'h22, 1'b0, 2, 8'hA5, 8'h3C, 1'b1};
        vecs[1] = '{7'h22, 1'b1, 2, 8'h5A, 8'hC3, 1'b1};
        vecs[2] = '{7'h23, 1'b0, 1, 8'h99, 8'h00, 1'b0};
        vecs[3] = '{7'h22, 1'b0, 1, 8'hFF, 8'h00, 1'b1};
        vecs[4] = '{7'h22, 1'b1, 1, 8'h00, 8'h00, 1'b1};
        vecs[5] = '{7'h11, 1'b1, 1, 8'h00, 8'h00, 1'b0};
        for (int i = 0; i < 16; i++) rd_mem[i] = 8'hEE;

        tick(5);
        check("rst_sda", 32'(sda_o), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op", 32'(xop), 32'd0);
        check("rst_wdat", 32'(wdat), 32'd0);
        check("rst_pulses", 32'({xs, wv, rr, sp}), 32'd0);
        check("rst_state", 32'(dut.state), 32'(ST_IDLE));
        rst = 1'b0;
        tick(4 * Q);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            tick(2 * Q);
        end

        xs0 = xs_cnt;
        wv0 = wv_cnt;
        sp0 = sp_cnt;
        rr0 = rd_idx;
        exp_op.push_back(1'b0);
        exp_op.push_back(1'b1);
        exp_wr.push_back(8'h11);
        rd_mem[4'(rr0)] = 8'h96;
        m_start();
        m_write(8'h44, a);
        check("sr_wr_addr_ack", 32'(a), 32'd0);
        m_write(8'h11, a);
        check("sr_wr_ack", 32'(a), 32'd0);
        m_start();
        check("sr_busy", 32'(busy), 32'd1);
        m_write(8'h45, a);
        check("sr_rd_addr_ack", 32'(a), 32'd0);
        m_read(1'b1, got);
        check("sr_rd_data", 32'(got), 32'h96);
        m_stop();
        tick(Q);
        check("sr_stop_cnt", 32'(sp_cnt - sp0), 32'd1);
        check("sr_xs_cnt", 32'(xs_cnt - xs0), 32'd2);
        check("sr_wv_cnt", 32'(wv_cnt - wv0), 32'd1);
        check("sr_rd_req", 32'(rd_idx - rr0), 32'd1);
        drain(xs0, wv0);
        tick(2 * Q);

        m_start();
        for (int i = 7; i >= 0; i--) bit_cyc(((8'h44 >> i) & 8'h01) != 0, r);
        check("ack_driven", 32'(sda_o), 32'd0);
        rst = 1'b1;
        tick(1);
        check("rst_mid_sda", 32'(sda_o), 32'd1);
        check("rst_mid_state", 32'(dut.state), 32'(ST_IDLE));
        check("rst_mid_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(4 * Q);
        v = '{7'h22, 1'b0, 1, 8'h77, 8'h00, 1'b1};
        run_vec(v);
        tick(2 * Q);

        wv0 = wv_cnt;
        sp0 = sp_cnt;
        m_start();
        m_write(8'h44, a);
        check("part_addr_ack", 32'(a), 32'd0);
        for (int i = 0; i < 4; i++) bit_cyc(i[0], r);
        m_stop();
        tick(Q);
        check("part_wv_cnt", 32'(wv_cnt - wv0), 32'd0);
        check("part_stop_cnt", 32'(sp_cnt - sp0), 32'd1);
        check("part_state", 32'(dut.state), 32'(ST_IDLE));
        check("part_busy", 32'(busy), 32'd0);
        exp_op.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- Synthesizable single-address I2C slave (target) that responds to the iicmb I2C master.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Receives address and write bytes, and drives read bytes and ACKs on SDA as an open-drain output.
- Hands bytes to and from a user-side byte interface; serves as the RTL counterpart of the I2C bus BFM in the iicmb bench.

Parameters:
- I2C_ADDR_WIDTH, 7, slave address width (only 7 is supported).
- I2C_DATA_WIDTH, 8, byte width (only 8 is supported).
- SLAVE_ADDR, 7'h22, address this block ACKs.
- SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i (minimum 2).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- scl_i  in  1  I2C clock from the bus (wired-AND resolved).
- sda_i  in  1  I2C data from the bus.
- sda_o  out  1  open-drain data drive; 0 = pull low, 1 = release.
- busy_o  out  1  high from a matched address until STOP.
- xfer_start_o  out  1  one-cycle pulse when the address matches and the ACK is committed.
- xfer_op_o  out  1  R/W bit of the current transfer (1 = read); valid from xfer_start_o until the next START.
- wr_valid_o  out  1  one-cycle pulse, received write byte.
- wr_data_o  out  8  write byte; valid while wr_valid_o is high, held until the next byte.
- rd_req_o  out  1  one-cycle pulse requesting the next read byte.
- rd_data_i  in  8  read byte; sampled in the cycle rd_req_o is high.
- stop_o  out  1  one-cycle pulse on a detected STOP (only while busy_o).

Behaviour:
- Reset: sda_o=1; all pulses 0; busy_o=0; xfer_op_o=0; wr_data_o=0; FSM=IDLE; bit counter=0. Reset mid-transfer releases SDA in the next cycle.
- Sync: scl_s and sda_s come from SYNC_STAGES flops, plus one history flop each.
  - scl_rise = scl_s & ~scl_d; scl_fall = ~scl_s & scl_d.
  - START = sda falling while scl_s=1; STOP = sda rising while scl_s=1.
  - Latency from pin edge to event is SYNC_STAGES+1 cycles.
- Sampling: data bits are sampled on scl_rise, MSB first. SDA changes only in the cycle after scl_fall.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
  - IDLE: START -> ADDR, counter=0.
  - ADDR: shift 8 bits (7 address + R/W). On the 8th scl_fall:
    - address match -> sda_o=0, pulse xfer_start_o, set busy_o and xfer_op_o, go to ADDR_ACK;
    - mismatch -> WAIT_STOP, sda_o stays 1.
  - ADDR_ACK: on scl_fall, release SDA.
    - Write -> WR_BYTE.
    - Read -> pulse rd_req_o, latch rd_data_i into the shift register, drive bit7 in the next cycle, go to RD_BYTE.
  - WR_BYTE: on the 8th scl_fall, sda_o=0 (ACK), pulse wr_valid_o, update wr_data_o, go to WR_ACK.
  - WR_ACK: on scl_fall, release SDA and return to WR_BYTE (counter=0).
  - RD_BYTE: after each scl_fall, shift out the next bit. After the 8th scl_fall, release SDA and go to RD_ACK.
  - RD_ACK: on scl_rise, sample the master's bit. On the following scl_fall:
    - ACK (0) -> pulse rd_req_o, load the next byte, go to RD_BYTE;
    - NACK (1) -> go to WAIT_STOP with SDA released.
  - WAIT_STOP: ignores the bus until START or STOP.
- START in any non-IDLE state (repeated START):
  - releases SDA, clears the counter, goes to ADDR;
  - busy_o stays high until the address phase resolves. A mismatch clears it, with no stop_o.
- STOP in any state: go to IDLE, sda_o=1, busy_o=0, pulse stop_o if busy_o was set. A partial byte is discarded (no wr_valid_o).
- START/STOP are only detected while SCL is high. An SDA edge in the same cycle as an SCL edge is treated as a data change, not START/STOP.
- Byte counts are unlimited; the counter is 3 bits wide and wraps 7->0 at byte boundaries.
- Stretching: none. The block never drives SCL.

Decomposition:
- i2c_pkg holds:
  - typedef i2c_slv_state_t (the FSM states);
  - constants I2C_ACK=1'b0, I2C_NACK=1'b1;
  - the existing i2c_op_t enum, reused for xfer_op_o encoding (WRITE=0, READ=1).
- One sub-module, i2c_line_sync: synchronizers, history flops, and the scl_rise/scl_fall/start/stop event outputs.

Test Plan:
- Write 0x22, bytes 0xA5, 0x3C, STOP -> xfer_start_o with xfer_op_o=0; wr_valid_o twice with wr_data_o=0xA5 then 0x3C; 3 ACKs on SDA; stop_o pulses once; busy_o returns to 0.
- Read 0x22 with rd_data_i=0x5A then 0xC3; master ACKs the first byte and NACKs the second -> SDA carries 0x5A then 0xC3 MSB-first; rd_req_o pulses exactly 2 times; SDA released after the NACK.
- Address 0x23 write -> no ACK (9th bit reads 1); no xfer_start_o or wr_valid_o; sda_o stays 1 through STOP.
- Write 0x22 with byte 0x11, repeated START, read 0x22 of 1 byte -> xfer_start_o twice, with xfer_op_o 0 then 1; a single stop_o at the end.
- rst_i asserted while sda_o=0 during an ACK -> sda_o=1 in the next cycle; FSM=IDLE; a subsequent write 0x22/0x77 works normally.
- STOP after 4 bits of a data byte -> no wr_valid_o; stop_o pulses; FSM=IDLE.
